// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: alignment/funct3 fault check, store lane steering with byte enables,
// and load byte/halfword extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic        is_store,
  input  logic [31:0] wd,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    fault = (f3 == F3_B)  ? 1'b0 :
            (f3 == F3_H)  ? off[0] :
            (f3 == F3_W)  ? (off != 2'b00) :
            (f3 == F3_BU) ? is_store :
            (f3 == F3_HU) ? (is_store | off[0]) : 1'b1;
    st_wdata = (f3 == F3_B) ? {4{wd[7:0]}} : (f3 == F3_H) ? {2{wd[15:0]}} : wd;
    st_be = !is_store     ? 4'b1111 :
            (f3 == F3_B)  ? 4'b0001 << off :
            (f3 == F3_H)  ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ld_byte = rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data = (ld_f3 == F3_B)  ? {{24{ld_byte[7]}}, ld_byte} :
              (ld_f3 == F3_H)  ? {{16{ld_half[15]}}, ld_half} :
              (ld_f3 == F3_BU) ? {24'd0, ld_byte} :
              (ld_f3 == F3_HU) ? {16'd0, ld_half} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: issues one word-aligned, byte-enabled memory access per load/store
// and stalls the core until the access retires in DONE.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        access_fault,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata
);
  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        fault, start;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;

  lsu_lane_align u_align (
    .f3(funct3), .off(addr[1:0]), .is_store(mem_write), .wd(write_data),
    .ld_f3(f3_q), .ld_off(off_q), .rdata(dmem_rdata),
    .fault(fault), .st_wdata(st_wdata), .st_be(st_be), .ld_data(ld_data)
  );

  assign start          = state_q == IDLE && (mem_read || mem_write);
  assign stall          = (start && !fault) || state_q == REQ || state_q == WAIT;
  assign access_fault   = start && fault;
  assign read_data      = access_fault ? 32'd0 : rdata_q;
  assign dmem_req_valid = state_q == REQ;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;

  // Request fields only load in IDLE, so they stay frozen through REQ until the handshake.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (start && !fault) begin
        state_d = REQ;
        we_d    = mem_write;
        addr_d  = {addr[31:2], 2'b00};
        wdata_d = st_wdata;
        be_d    = st_be;
        f3_d    = funct3;
        off_d   = addr[1:0];
      end
      REQ:  if (dmem_req_ready) state_d = we_q ? DONE : WAIT;
      WAIT: if (dmem_resp_valid) begin
        rdata_d = ld_data;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of the LSU against a byte-array memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, write_data = 32'd0;
  logic [31:0] read_data, dmem_addr, dmem_wdata;
  logic        stall, access_fault, dmem_req_valid, dmem_we;
  logic [3:0]  dmem_be;
  logic        dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  mem_b [1024];
  logic [7:0]  ref_b [1024];
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data), .read_data(read_data),
    .stall(stall), .access_fault(access_fault), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_resp_valid(dmem_resp_valid),
    .dmem_rdata(dmem_rdata)
  );

  function automatic int sz(input logic [2:0] f);
    return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic legal(input logic st, input logic [2:0] f, input logic [31:0] a);
    if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b0;
    if (st && f[2]) return 1'b0;
    return (int'(a[1:0]) % sz(f)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    longint v = 0;
    int n = sz(f);
    for (int k = 0; k < n; k++) v += longint'(ref_b[int'(a[9:0]) + k]) << (8 * k);
    if (!f[2] && n < 4 && v[8 * n - 1]) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic st, input logic [2:0] f, input logic [31:0] a);
    logic [3:0] be = 4'd0;
    if (!st) return 4'b1111;
    for (int k = 0; k < sz(f); k++) be[int'(a[1:0]) + k] = 1'b1;
    return be;
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < sz(f); k++) ref_b[int'(a[9:0]) + k] = 8'(wd >> (8 * k));
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      mem_b[int'(a[9:0]) + k] = 8'(w >> (8 * k));
      ref_b[int'(a[9:0]) + k] = 8'(w >> (8 * k));
    end
  endtask

  // Drives one access and plays the memory side; returns what was observed.
  task automatic do_access(input logic st, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, input int rdly, input int wdly,
                           output int stalls, output int hs, output logic v0, output logic v1,
                           output logic [31:0] c_addr, output logic [31:0] c_wdata,
                           output logic [3:0] c_be, output logic c_we, output logic unstable,
                           output logic to, output logic [31:0] rd);
    int nreq, nw;
    logic in_wait, done;
    @(negedge clk);
    mem_read = !st; mem_write = st; funct3 = f; addr = a; write_data = wd;
    stalls = 0; hs = 0; nreq = 0; nw = 0; in_wait = 0; done = 0; unstable = 0;
    v0 = 0; v1 = 0; c_addr = 0; c_wdata = 0; c_be = 0; c_we = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = $urandom();
      if (c == 0) v0 = dmem_req_valid;
      if (c == 1) v1 = dmem_req_valid;
      if (!stall) done = 1;
      else begin
        stalls++;
        if (dmem_req_valid) begin
          if (nreq == 0) begin
            c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
          end else if ({dmem_addr, dmem_wdata, dmem_be, dmem_we} !== {c_addr, c_wdata, c_be, c_we})
            unstable = 1;
          if (nreq >= rdly) begin
            dmem_req_ready = 1'b1; hs++; in_wait = !dmem_we;
            if (dmem_we)
              for (int i = 0; i < 4; i++)
                if (dmem_be[i]) mem_b[{dmem_addr[9:2], 2'(i)}] = dmem_wdata[8 * i +: 8];
          end
          nreq++;
        end else if (in_wait) begin
          dmem_rdata = {mem_b[{c_addr[9:2], 2'd3}], mem_b[{c_addr[9:2], 2'd2}],
                        mem_b[{c_addr[9:2], 2'd1}], mem_b[{c_addr[9:2], 2'd0}]};
          if (nw >= wdly) begin dmem_resp_valid = 1'b1; in_wait = 0; end
          nw++;
        end
      end
    end
    to = !done;
    rd = read_data;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_fault(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_read = !st; mem_write = st; funct3 = f; addr = a; write_data = wd;
    #1;
    n_cmp++;
    if ({access_fault, stall, dmem_req_valid, read_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL fault_resp f3=%0b a=%h got fault=%b stall=%b valid=%b rd=%h want 1 0 0 0",
               f, a, access_fault, stall, dmem_req_valid, read_data);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (dmem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL fault_no_req got valid=%b want 0", dmem_req_valid);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    n_cmp++;
    if ({access_fault, read_data} !== {1'b0, last_load}) begin
      n_err++;
      $display("FAIL fault_release got fault=%b rd=%h want 0 %h", access_fault, read_data, last_load);
    end
  endtask

  int stalls, hs;
  logic v0, v1, c_we, unstable, to;
  logic [31:0] c_addr, c_wdata, rd;
  logic [3:0] c_be;

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_cmp++;
    if ({dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_be, read_data} !== '0) begin
      n_err++;
      $display("FAIL reset_regs got v=%b we=%b a=%h wd=%h be=%b rd=%h want all 0",
               dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_be, read_data);
    end
    n_cmp++;
    if ({stall, access_fault} !== 2'b00) begin
      n_err++; $display("FAIL reset_stall got stall=%b fault=%b want 0 0", stall, access_fault);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_word();
    poke(32'h100, 32'hDEADBEEF);
    do_access(0, 3'b010, 32'h100, 0, 0, 0, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
    n_cmp++;
    if ({to, hs, stalls} !== {1'b0, 32'd1, 32'd3}) begin
      n_err++; $display("FAIL lw_timing got to=%b hs=%0d stalls=%0d want 0 1 3", to, hs, stalls);
    end
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got %h want deadbeef", rd); end
    n_cmp++;
    if ({c_addr, c_be, c_we, v0, v1} !== {32'h100, 4'b1111, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL lw_req got a=%h be=%b we=%b v0=%b v1=%b want 100 1111 0 0 1", c_addr, c_be, c_we, v0, v1);
    end
    last_load = 32'hDEADBEEF;
  endtask

  task automatic test_load_ext();
    logic [2:0]  fs [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    logic [31:0] as [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h0000007F};
    poke(32'h100, 32'h80FFFF7F);
    for (int i = 0; i < 5; i++) begin
      do_access(0, fs[i], as[i], 0, i % 2, i % 3, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
      n_cmp++;
      if (rd !== ex[i] || to) begin
        n_err++; $display("FAIL load_ext f3=%0b a=%h got %h want %h to=%b", fs[i], as[i], rd, ex[i], to);
      end
      last_load = ex[i];
    end
  endtask

  task automatic test_store_wait();
    do_access(1, 3'b001, 32'h206, 32'h1234ABCD, 3, 0, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
    model_store(3'b001, 32'h206, 32'h1234ABCD);
    n_cmp++;
    if ({c_addr, c_wdata, c_be, c_we} !== {32'h204, 32'hABCDABCD, 4'b1100, 1'b1}) begin
      n_err++;
      $display("FAIL sh_req got a=%h wd=%h be=%b we=%b want 204 abcdabcd 1100 1", c_addr, c_wdata, c_be, c_we);
    end
    n_cmp++;
    if ({unstable, to, hs, stalls} !== {1'b0, 1'b0, 32'd1, 32'd5}) begin
      n_err++;
      $display("FAIL sh_timing got unstable=%b to=%b hs=%0d stalls=%0d want 0 0 1 5", unstable, to, hs, stalls);
    end
    n_cmp++;
    if (rd !== last_load) begin n_err++; $display("FAIL sh_rd_hold got %h want %h", rd, last_load); end
    do_access(0, 3'b010, 32'h204, 0, 0, 1, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
    n_cmp++;
    if (rd !== model_load(3'b010, 32'h204)) begin
      n_err++; $display("FAIL sh_readback got %h want %h", rd, model_load(3'b010, 32'h204));
    end
    last_load = model_load(3'b010, 32'h204);
  endtask

  task automatic test_fault();
    do_fault(0, 3'b010, 32'h101, 0);
    do_fault(1, 3'b001, 32'h003, 32'h55AA55AA);
    do_fault(1, 3'b100, 32'h010, 0);
    do_fault(0, 3'b111, 32'h010, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk); #1;
    dmem_req_ready = 1'b1;
    @(negedge clk); #1;
    dmem_req_ready = 1'b0;
    n_cmp++;
    if ({stall, dmem_req_valid} !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_wait got stall=%b valid=%b want 1 0", stall, dmem_req_valid);
    end
    #1 reset = 1'b0; mem_read = 1'b0;
    #1;
    n_cmp++;
    if ({dmem_req_valid, stall, read_data} !== {1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL rst_mid_async got valid=%b stall=%b rd=%h want 0 0 0", dmem_req_valid, stall, read_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem_resp_valid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({dmem_req_valid, stall, read_data} !== {1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL rst_late_resp got valid=%b stall=%b rd=%h want 0 0 0", dmem_req_valid, stall, read_data);
    end
    last_load = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd = $urandom();
    do_access(1, 3'b000, 32'h300, wd, 0, 0, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
    model_store(3'b000, 32'h300, wd);
    n_cmp++;
    if ({hs, stalls, c_be} !== {32'd1, 32'd2, 4'b0001}) begin
      n_err++; $display("FAIL b2b_sb got hs=%0d stalls=%0d be=%b want 1 2 0001", hs, stalls, c_be);
    end
    do_access(0, 3'b010, 32'h300, 0, 0, 0, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
    n_cmp++;
    if ({v0, v1, hs, stalls} !== {1'b0, 1'b1, 32'd1, 32'd3}) begin
      n_err++; $display("FAIL b2b_lw_issue got v0=%b v1=%b hs=%0d stalls=%0d want 0 1 1 3", v0, v1, hs, stalls);
    end
    n_cmp++;
    if (rd !== model_load(3'b010, 32'h300)) begin
      n_err++; $display("FAIL b2b_lw_data got %h want %h", rd, model_load(3'b010, 32'h300));
    end
    last_load = model_load(3'b010, 32'h300);
  endtask

  task automatic test_random();
    logic st;
    logic [2:0] f;
    logic [31:0] a, wd, exp_rd;
    int rdly, wdly, exp_st;
    for (int it = 0; it < 120; it++) begin
      st = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && !legal(st, f, 32'd0)) f = 3'($urandom_range(0, 2));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz(f) - 1);
      wd = $urandom();
      rdly = $urandom_range(0, 3);
      wdly = $urandom_range(0, 3);
      if (!legal(st, f, a)) begin
        do_fault(st, f, a, wd);
        continue;
      end
      exp_rd = st ? last_load : model_load(f, a);
      exp_st = st ? 2 + rdly : 3 + rdly + wdly;
      do_access(st, f, a, wd, rdly, wdly, stalls, hs, v0, v1, c_addr, c_wdata, c_be, c_we, unstable, to, rd);
      if (st) model_store(f, a, wd); else last_load = exp_rd;
      n_cmp++;
      if (rd !== exp_rd) begin
        n_err++; $display("FAIL rand_data it=%0d st=%b f3=%0b a=%h got %h want %h", it, st, f, a, rd, exp_rd);
      end
      n_cmp++;
      if ({to, unstable, hs, stalls} !== {1'b0, 1'b0, 32'd1, exp_st}) begin
        n_err++;
        $display("FAIL rand_timing it=%0d got to=%b unstable=%b hs=%0d stalls=%0d want 0 0 1 %0d",
                 it, to, unstable, hs, stalls, exp_st);
      end
      n_cmp++;
      if ({c_addr, c_be, c_we} !== {a[31:2], 2'b00, model_be(st, f, a), st}) begin
        n_err++;
        $display("FAIL rand_req it=%0d got a=%h be=%b we=%b want %h %b %b",
                 it, c_addr, c_be, c_we, {a[31:2], 2'b00}, model_be(st, f, a), st);
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_b[i] = 8'($urandom());
      ref_b[i] = mem_b[i];
    end
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_wait();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core datapath and a handshaked data memory. It takes the datapath's effective address (ALU result), store data and load/store control, then issues one word-aligned memory transaction with byte enables. It returns sign- or zero-extended load data to the result mux. While an access is in flight it stalls the core, holding the PC and suppressing register writeback.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store. mem_read and mem_write are never both 1.
- funct3  in  3  access size and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu for loads; 000 sb, 001 sh, 010 sw for stores.
- addr  in  32  effective byte address (datapath alu_result).
- write_data  in  32  store source (rs2).
- read_data  out  32  formatted load result (feeds result mux input d1).
- stall  out  1  core must hold the PC and must not write the register file.
- access_fault  out  1  misaligned address or illegal funct3 on the current access.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  {addr[31:2], 2'b00}.
- dmem_wdata  out  32  lane-steered store data.
- dmem_be  out  4  byte enables.
- dmem_resp_valid  in  1  read data valid; reads only.
- dmem_rdata  in  32  read word.

## Operation
- FSM states:
  - IDLE: no access active. An access is requested when mem_read|mem_write is 1. If the request is legal, register the request fields and go to REQ. If it is a fault, stay in IDLE.
  - REQ: dmem_req_valid=1. On dmem_req_ready=1: a store goes to DONE; a load goes to WAIT.
  - WAIT: on dmem_resp_valid=1, register the formatted dmem_rdata into read_data and go to DONE.
  - DONE: stall=0 for one cycle, so the core retires the instruction. Always return to IDLE; mem_read/mem_write are not re-sampled in DONE.
- stall: combinational, 1 when (IDLE & legal access) or state ∈ {REQ, WAIT}. It is 0 in DONE and for faulting accesses.
- Fault conditions:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - funct3 ∈ {011, 110, 111};
  - funct3 ∈ {100, 101} on a store.
- Fault response: access_fault=1 combinationally in IDLE, no memory request, and read_data is driven 0 for that cycle.
- Store steering:
  - sb: wdata={4{wd[7:0]}}, be=4'b0001<<addr[1:0].
  - sh: wdata={2{wd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - sw: wdata=wd, be=1111.
- Load extraction: select the byte/halfword by addr[1:0] from dmem_rdata. Sign-extend for lb/lh, zero-extend for lbu/lhu; lw passes the word through.
- Reads drive dmem_be=1111. Memory ignores be on reads.
- Request fields (dmem_we/addr/wdata/be) are registered. They are stable from REQ entry until the handshake.
- dmem_resp_valid outside WAIT is ignored.

## Timing
- Reset (async assert): state=IDLE; dmem_req_valid=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, read_data=0; stall and access_fault are driven from the idle state with no access.
- Minimum load with ready=1 and response one cycle later: C0 IDLE (stall=1), C1 REQ handshake, C2 WAIT resp, C3 DONE (read_data valid, stall=0). The instruction occupies 4 cycles.
- Minimum store: C0 IDLE, C1 REQ handshake, C2 DONE. 3 cycles.
- Each ready=0 cycle in REQ, or each resp_valid=0 cycle in WAIT, adds one stall cycle.
- read_data holds its last loaded value until the next load completes, except in fault cycles.
- Reset asserted mid-access in REQ or WAIT: valid drops immediately and state goes to IDLE. A late response after reset release is ignored.
- Back-to-back accesses: the next access is sampled in the IDLE cycle after DONE. There is no pipelining of requests.

## Structure
- Package lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
- Sub-module lsu_lane_align, purely combinational. It holds the fault check, store steering / byte-enable generation, and load extraction/extension. It is instanced once; the FSM and registers stay in load_store_unit.

## Test plan
- lw addr=0x100, ready=1, rdata=0xDEADBEEF after 1 cycle -> stall high for 3 cycles, then read_data=0xDEADBEEF, dmem_addr=0x100, be=1111.
- lb addr=0x103 with rdata=0x80FF_FF7F gives read_data=0xFFFFFF80; lbu at the same address gives 0x00000080; lhu at 0x102 gives 0x000080FF.
- sh addr=0x206, wd=0x1234ABCD, ready held 0 for 3 cycles -> dmem_addr=0x204, wdata=0xABCDABCD, be=1100 held stable throughout; stall lasts 5 cycles.
- lw addr=0x101 and sh addr=0x003 -> access_fault=1, stall=0, dmem_req_valid stays 0, read_data=0.
- Reset asserted in WAIT, then resp_valid pulsed after release -> state IDLE, valid=0, read_data=0, response ignored.
- sb followed immediately by lw -> second request issued in the cycle after DONE with no lost or duplicated transaction.
